// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the imem req/ack handshake, hands words to decode.
// Optional MISALIGN_TRAP_EN: misaligned redirects load TRAP_VEC and pulse trap.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        trap
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state, state_d;
    logic [31:0] drop_addr, drop_d;
    logic [31:0] pc_d, instr_d, ipc_d, tgt;
    logic        mis, trap_d;

`ifdef MISALIGN_TRAP_EN
    assign mis = |redirect_pc[1:0];
`else
    assign mis = 1'b0;
`endif
    assign tgt = mis ? TRAP_VEC : redirect_pc;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        drop_d  = drop_addr;
        instr_d = instr;
        ipc_d   = instr_pc;
        trap_d  = redirect_valid & mis;
        case (state)
            IDLE: begin
                if (redirect_valid) pc_d = tgt;
                state_d = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_d = tgt;
                    // An un-acked request cannot be withdrawn; remember it so it can be drained.
                    if (!imem_ack) begin
                        drop_d  = pc;
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc;
                    pc_d    = pc + 32'd4;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = tgt;
                    state_d = REQ;
                end else if (instr_ready) begin
                    state_d = REQ;
                end
            end
            DROP: begin
                if (redirect_valid) pc_d = tgt;
                if (imem_ack) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop_addr   <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            trap        <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            drop_addr   <= drop_d;
            instr       <= instr_d;
            instr_pc    <= ipc_d;
            trap        <= trap_d;
            imem_req    <= (state_d == REQ) || (state_d == DROP);
            imem_addr   <= (state_d == DROP) ? drop_d : pc_d;
            instr_valid <= (state_d == HOLD);
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; memory returns a scrambled copy of the address.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        trap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = rd(imem_addr);

    pc_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc), .trap(trap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h/%h exp 0/0", instr, instr_pc); end
        checks++; if (pc !== 32'h0 || trap !== 1'b0) begin errors++; $display("FAIL rst_pc_trap: got %h/%b exp 0/0", pc, trap); end
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL idle_to_req: got %b/%h exp 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_free_run();
        logic [31:0] a;
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 32'(k * 4);
            checks++; if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0) begin
                errors++; $display("FAIL run_req%0d: got req=%b addr=%h vld=%b exp 1/%h/0", k, imem_req, imem_addr, instr_valid, a); end
            tick();
            checks++; if (instr_valid !== 1'b1 || instr_pc !== a || instr !== rd(a) || pc !== a + 32'd4 || imem_req !== 1'b0) begin
                errors++; $display("FAIL run_hold%0d: got vld=%b ipc=%h instr=%h pc=%h req=%b exp 1/%h/%h/%h/0", k, instr_valid, instr_pc, instr, pc, imem_req, a, rd(a), a + 32'd4); end
            tick();
        end
    endtask

    task automatic test_ack_delay();
        tick();          // REQ 0xC acked -> HOLD
        imem_ack = 1'b0;
        tick();          // HOLD -> REQ at 0x10
        for (int k = 0; k < 3; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL delay_wait%0d: got req=%b addr=%h vld=%b exp 1/00000010/0", k, imem_req, imem_addr, instr_valid); end
            if (k < 2) tick();
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== rd(32'h10)) begin
            errors++; $display("FAIL delay_valid: got vld=%b ipc=%h instr=%h exp 1/00000010/%h", instr_valid, instr_pc, instr, rd(32'h10)); end
    endtask

    task automatic test_hold_stall();
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || pc !== 32'h14 || instr !== rd(32'h10) || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall%0d: got vld=%b ipc=%h pc=%h instr=%h req=%b exp 1/10/14/%h/0", k, instr_valid, instr_pc, pc, instr, imem_req, rd(32'h10)); end
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200 || pc !== 32'h200) begin
            errors++; $display("FAIL hold_redirect: got vld=%b req=%b addr=%h pc=%h exp 0/1/200/200", instr_valid, imem_req, imem_addr, pc); end
    endtask

    task automatic test_redirect_drop();
        // Redirect with same-cycle ack: data discarded, straight to new request.
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            errors++; $display("FAIL req_ack_redirect: got vld=%b req=%b addr=%h exp 0/1/20", instr_valid, imem_req, imem_addr); end
        imem_ack = 1'b0; redirect_pc = 32'h90;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || pc !== 32'h90 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL drop_enter: got req=%b addr=%h pc=%h vld=%b exp 1/20/90/0", imem_req, imem_addr, pc, instr_valid); end
        redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || pc !== 32'h80 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL drop_last_wins: got req=%b addr=%h pc=%h vld=%b exp 1/20/80/0", imem_req, imem_addr, pc, instr_valid); end
        imem_ack = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            errors++; $display("FAIL drop_ack: got vld=%b req=%b addr=%h exp 0/1/80", instr_valid, imem_req, imem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h80 || instr !== rd(32'h80)) begin
            errors++; $display("FAIL drop_next_fetch: got vld=%b ipc=%h instr=%h exp 1/80/%h", instr_valid, instr_pc, instr, rd(32'h80)); end
        instr_ready = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h84 || imem_req !== 1'b1) begin
            errors++; $display("FAIL drop_seq: got addr=%h req=%b exp 84/1", imem_addr, imem_req); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got %h exp fffffffc", imem_addr); end
        tick();
        checks++; if (instr_pc !== 32'hFFFF_FFFC || pc !== 32'h0 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_pc: got ipc=%h pc=%h vld=%b exp fffffffc/0/1", instr_pc, pc, instr_valid); end
        tick();
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_addr: got %h/%b exp 0/1", imem_addr, imem_req); end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_addr;
        logic        exp_trap;
`ifdef MISALIGN_TRAP_EN
        exp_addr = 32'h100; exp_trap = 1'b1;
`else
        exp_addr = 32'h102; exp_trap = 1'b0;
`endif
        tick();          // ack at 0 -> HOLD
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        checks++; if (trap !== exp_trap || imem_addr !== exp_addr || instr_valid !== 1'b0) begin
            errors++; $display("FAIL misalign_redirect: got trap=%b addr=%h vld=%b exp %b/%h/0", trap, imem_addr, instr_valid, exp_trap, exp_addr); end
        tick();
        checks++; if (trap !== 1'b0 || instr_pc !== exp_addr) begin
            errors++; $display("FAIL misalign_after: got trap=%b ipc=%h exp 0/%h", trap, instr_pc, exp_addr); end
    endtask

    task automatic test_reset_midreq();
        instr_ready = 1'b1; imem_ack = 1'b0;
        tick();          // HOLD -> REQ, no ack
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midreq_pre: got %b exp 1", imem_req); end
        rst_n = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL midreq_rst: got req=%b addr=%h pc=%h vld=%b exp 0/0/0/0", imem_req, imem_addr, pc, instr_valid); end
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL midreq_restart: got %b/%h exp 1/0", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ack_delay();
        test_hold_stall();
        test_redirect_drop();
        test_wrap();
        test_misalign();
        test_reset_midreq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
